// File: rtl/snake_body_tracker.sv
// Snake body state: segment coords, length, heading, wall/self collision.
// Ports: clk, reset, move_tick, dir, apple_xy -> body, length, good_coll, dead, busy.
module snake_body_tracker #(
  parameter int MAX_LENGTH = 16,
  parameter int START_LEN  = 3,
  localparam int LW = $clog2(MAX_LENGTH + 1)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        move_tick,
  input  logic [1:0]                  dir,
  input  logic [7:0]                  apple_xy,
  output logic [MAX_LENGTH-1:0][7:0]  body,
  output logic [LW-1:0]               length,
  output logic                        good_coll,
  output logic                        dead,
  output logic                        busy
);

  typedef enum logic [1:0] {
    S_WAIT,
    S_STEP,
    S_CHECK,
    S_DEAD
  } state_t;

  state_t     state;
  logic [1:0] heading;
  logic       eat_q;

  logic [3:0] hx, hy;
  logic       wall;
  logic [7:0] nh;
  logic       eat, grow;
  logic [LW-1:0] nlen;
  logic [7:0] ntail;
  logic [MAX_LENGTH-1:0][7:0] nb;
  logic       self_hit;
  logic       rev;

  function automatic logic [7:0] init_seg(int i);
    int j;
    j = (i < START_LEN) ? i : START_LEN - 1;
    return {4'(4 - j), 4'h8};
  endfunction

  assign hx = body[0][7:4];
  assign hy = body[0][3:0];

  // up/down share bit1=0, left/right bit1=1; reverse flips bit0 only
  assign rev = (dir[1] == heading[1]) && (dir[0] != heading[0]);

  always_comb begin
    wall = 1'b0;
    nh   = body[0];
    unique case (heading)
      2'b00: begin wall = (hy == 4'd0);  nh = {hx, hy - 4'd1}; end
      2'b01: begin wall = (hy == 4'd15); nh = {hx, hy + 4'd1}; end
      2'b10: begin wall = (hx == 4'd0);  nh = {hx - 4'd1, hy}; end
      2'b11: begin wall = (hx == 4'd15); nh = {hx + 4'd1, hy}; end
    endcase
  end

  assign eat  = (nh == apple_xy);
  assign grow = eat && (length < LW'(MAX_LENGTH));
  assign nlen = grow ? length + LW'(1) : length;

  // When growing, the shift already leaves the old tail in every slot
  // past the new length; when not, the new tail is old body[length-2].
  always_comb begin
    ntail = body[0];
    for (int k = 0; k < MAX_LENGTH; k++)
      if (k == int'(length) - 2) ntail = body[k];
    nb[0] = nh;
    for (int i = 1; i < MAX_LENGTH; i++)
      nb[i] = body[i-1];
    if (!grow)
      for (int i = 0; i < MAX_LENGTH; i++)
        if (i >= int'(length)) nb[i] = ntail;
  end

  always_comb begin
    self_hit = 1'b0;
    for (int k = 1; k < MAX_LENGTH; k++)
      if (k < int'(length) && body[k] == body[0]) self_hit = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_WAIT;
      heading   <= 2'b11;
      length    <= LW'(START_LEN);
      eat_q     <= 1'b0;
      good_coll <= 1'b0;
      dead      <= 1'b0;
      busy      <= 1'b0;
      for (int i = 0; i < MAX_LENGTH; i++)
        body[i] <= init_seg(i);
    end else begin
      good_coll <= 1'b0;
      unique case (state)
        S_WAIT: begin
          if (move_tick) begin
            if (!rev) heading <= dir;
            state <= S_STEP;
            busy  <= 1'b1;
          end
        end
        S_STEP: begin
          if (wall) begin
            state <= S_DEAD;
            dead  <= 1'b1;
          end else begin
            body   <= nb;
            length <= nlen;
            eat_q  <= eat;
            state  <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (self_hit) begin
            state <= S_DEAD;
            dead  <= 1'b1;
          end else begin
            state     <= S_WAIT;
            busy      <= 1'b0;
            good_coll <= eat_q;
          end
        end
        S_DEAD: begin
        end
      endcase
    end
  end

endmodule
